wifi_tx_arbiter: RTL
====================

# wifi_tx_arbiter

Packet-level arbiter that shares the single ESP8266 UART transmitter between two byte-stream requesters: A, the AT-command sequencer, and B, the application payload source (e.g. HTTP GET lines after configuration). It sits between the requesters and `uart_tx`. It grants whole packets round-robin and paces bytes so each `po_flag` pulse is spaced one full UART byte slot apart, because `uart_tx` has no ready signal. It also releases a stalled owner after a timeout.

## Interface
- `CLK_FRE`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, UART baud rate.
- `SLOT_BITS`, 11, bit-times per byte slot (10 frame bits plus 1 guard bit).
- `STALL_MAX`, 1_000_000, cycles an owner may hold `valid` low mid-packet before its lock is revoked. Must be ≥1.
- Derived: BYTE_CYC = (CLK_FRE/BAUD_RATE)*SLOT_BITS, integer division first. Default: 434*11 = 4774. Must be ≥2.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `a_data`  in  8  requester A byte.
- `a_valid`  in  1  A byte available. Data and `a_last` are held stable until accepted.
- `a_last`  in  1  marks the final byte of A's packet.
- `a_ready`  out  1  A byte accepted this cycle when `a_valid` is also high.
- `b_data`, `b_valid`, `b_last`, `b_ready`: same as the A ports, for requester B.
- `po_data`  out  8  byte to `uart_tx.pi_data`.
- `po_flag`  out  1  one-cycle strobe to `uart_tx.pi_flag`.
- `grant`  out  2  one-hot owner: 01 = A, 10 = B, 00 = none.
- `busy`  out  1  high whenever the state is not IDLE.
- `stall_err`  out  1  one-cycle pulse when a lock is revoked by timeout.

## Operation
- One clock, `sys_clk`. Asynchronous active-high reset `sys_rst`.
- FSM states: IDLE, XFER, GAP.
- Registers: owner, rr_ptr (the requester last served), last_q, slot counter, stall counter.

IDLE:
- If only one requester has `valid` high, that requester becomes owner.
- If both are high, the owner is the requester not equal to rr_ptr. rr_ptr resets to B, so A wins the first tie.
- On choosing an owner: set `grant` and go to XFER.

XFER:
- The owner's `ready` is high (combinational from state and owner). The other requester's `ready` is 0.
- On owner `valid` high (transfer):
  - next cycle: `po_data` = owner data and `po_flag` = 1;
  - last_q is set to the owner's `last`;
  - the slot counter loads BYTE_CYC-2;
  - the stall counter clears;
  - go to GAP.
- While owner `valid` is low, the stall counter increments. When it reaches STALL_MAX-1:
  - go to IDLE, pulse `stall_err`, clear `grant`;
  - rr_ptr is set to the owner.

GAP:
- The slot counter decrements each cycle.
- When the counter reads 0: if last_q is set, go to IDLE with rr_ptr set to owner and `grant` cleared. Otherwise go to XFER.
- `ready` is 0 for both requesters.

General rules:
- A non-owner's `valid` never preempts an open packet.
- `po_data` holds its last value between strobes.
- Counters are sized for BYTE_CYC and STALL_MAX. They never wrap in normal operation.

## Timing
- Reset values:
  - `po_data` = 0x00; `po_flag`, `a_ready`, `b_ready`, `busy`, `stall_err` = 0; `grant` = 00;
  - state IDLE, rr_ptr = B, all counters 0.
  - A reset mid-packet truncates any `po_flag` pulse and drops the lock.
- Latency: `valid` rises while IDLE at cycle n → XFER and `ready` high at n+1 → `po_flag` at n+2.
- Within a packet, with `valid` continuously high: `po_flag` pulses are exactly BYTE_CYC cycles apart (4774 by default).
- Between packets: the last byte's `po_flag` at cycle t → IDLE at t+BYTE_CYC-1 → the next packet's first `po_flag` at ≥ t+BYTE_CYC+1.
- A stalled owner delays the next `po_flag` by exactly the stall duration.
- Simultaneous rise of `a_valid` and `b_valid` in IDLE: resolved by rr_ptr only.
- A requester dropping `valid` in the same cycle `ready` rises: no transfer. Stall counting starts that cycle.
- A single-byte packet (`last` = 1 on the first byte) is legal.

## Test plan
- Reset, then `a_valid` with bytes 0x41, 0x54 (last) → `grant` = 01, `po_flag` at n+2 with 0x41, then 0x54 exactly 4774 cycles later, `busy` low afterwards.
- `a_valid` and `b_valid` rise together from reset → A is served first. B's first `po_flag` comes ≥4775 cycles after A's last; B's `ready` stays 0 throughout A's packet.
- Back-to-back packets from both requesters → grants alternate A, B, A, B, with no requester served twice in a row while the other is pending.
- STALL_MAX = 16: A sends one non-last byte, then holds `valid` low → `stall_err` pulses once, `grant` goes 00, and a pending B wins the next grant.
- Assert `sys_rst` during GAP of a 3-byte packet → all outputs go to their reset values immediately. After release, an idle bench produces no `po_flag`.
- Single-byte B packet 0x0D (last) → exactly one `po_flag`, then IDLE after 4773 cycles in GAP.

Source files
------------

// File: rtl/wifi_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one UART transmitter between two
// byte-stream requesters, spacing po_flag strobes one full byte slot apart.
module wifi_tx_arbiter #(
  parameter int unsigned CLK_FRE   = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned SLOT_BITS = 11,
  parameter int unsigned STALL_MAX = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  input  logic       a_last,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  input  logic       b_last,
  output logic       b_ready,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic [1:0] grant,
  output logic       busy,
  output logic       stall_err
);

  localparam int unsigned BYTE_CYC = (CLK_FRE / BAUD_RATE) * SLOT_BITS;
  localparam int unsigned SLOT_W   = (BYTE_CYC > 2) ? $clog2(BYTE_CYC) : 1;
  localparam int unsigned STALL_W  = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               own_b_q, own_b_d;     // current owner: 0 = A, 1 = B
  logic               rr_b_q, rr_b_d;       // last requester served: 0 = A, 1 = B
  logic               last_q, last_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [7:0]         po_data_q, po_data_d;
  logic               po_flag_q, po_flag_d;
  logic [1:0]         grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               stall_err_q, stall_err_d;

  logic       own_valid;
  logic [7:0] own_data;
  logic       own_last;

  assign own_valid = own_b_q ? b_valid : a_valid;
  assign own_data  = own_b_q ? b_data  : a_data;
  assign own_last  = own_b_q ? b_last  : a_last;

  assign a_ready   = (state_q == S_XFER) && !own_b_q;
  assign b_ready   = (state_q == S_XFER) &&  own_b_q;
  assign po_data   = po_data_q;
  assign po_flag   = po_flag_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign stall_err = stall_err_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    own_b_d     = own_b_q;
    rr_b_d      = rr_b_q;
    last_d      = last_q;
    slot_d      = slot_q;
    stall_d     = stall_q;
    po_data_d   = po_data_q;
    po_flag_d   = 1'b0;
    stall_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (a_valid || b_valid) begin
          state_d = S_XFER;
          own_b_d = (a_valid && b_valid) ? ~rr_b_q : b_valid;
        end
      end
      S_XFER: begin
        if (own_valid) begin
          po_data_d = own_data;
          po_flag_d = 1'b1;
          last_d    = own_last;
          slot_d    = SLOT_W'(BYTE_CYC - 2);
          stall_d   = '0;
          state_d   = S_GAP;
        end else if (stall_q == STALL_W'(STALL_MAX - 1)) begin
          // Owner went silent mid-packet: revoke the lock so the other side can run
          state_d     = S_IDLE;
          stall_err_d = 1'b1;
          rr_b_d      = own_b_q;
          stall_d     = '0;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      S_GAP: begin
        if (slot_q == '0) begin
          if (last_q) begin
            state_d = S_IDLE;
            rr_b_d  = own_b_q;
          end else begin
            state_d = S_XFER;
          end
        end else begin
          slot_d = slot_q - SLOT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    grant_d = (state_d == S_IDLE) ? 2'b00 : (own_b_d ? 2'b10 : 2'b01);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      own_b_q     <= 1'b0;
      rr_b_q      <= 1'b1;
      last_q      <= 1'b0;
      slot_q      <= '0;
      stall_q     <= '0;
      po_data_q   <= 8'h00;
      po_flag_q   <= 1'b0;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_b_q     <= own_b_d;
      rr_b_q      <= rr_b_d;
      last_q      <= last_d;
      slot_q      <= slot_d;
      stall_q     <= stall_d;
      po_data_q   <= po_data_d;
      po_flag_q   <= po_flag_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      stall_err_q <= stall_err_d;
    end
  end

endmodule
